// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared types and constants for the SPI register bank
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // shift the raw input through the chain; remember the last synchronized value
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // synchronizer and edge-history flops, reset to the line's idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI mode-0 peripheral giving burst access to a register bank
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter int                NUM_REGS    = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    localparam int CNT_W      = $clog2(ADDR_W + DATA_W + 1);
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SETTLE_MAX = SYNC_STAGES + 2;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(nCS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(COPI), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]     hdr_q, hdr_d;
    logic                  rw_q, rw_d;
    logic                  bad_q, bad_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wsr_q, wsr_d;
    logic [DATA_W-1:0]     rsr_q, rsr_d;
    logic                  skip_q, skip_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  armed_q, armed_d;

    logic [ADDR_W:0]       hdr_full;
    logic [ADDR_W-1:0]     hdr_addr, addr_next;
    logic                  hdr_bad;
    logic [DATA_W-1:0]     word;
    logic [IDX_W-1:0]      hidx, aidx, nidx;

    logic unused_sig;
    assign unused_sig = ^{sclk_lvl, copi_rise, copi_fall, wsr_q[DATA_W-1]};

    // After reset the nCS chain flushes from its idle value; a fall seen while it settles
    // belongs to a frame already in progress and must not start a new one.
    always_comb begin
        settle_d = settle_q;
        armed_d  = armed_q;
        if (settle_q != SETTLE_W'(SETTLE_MAX)) begin
            settle_d = settle_q + 1'b1;
        end else if (cs_lvl) begin
            armed_d = 1'b1;
        end
    end

    // frame decode, per-word commit/reload and end-of-frame error accounting
    always_comb begin
        hdr_full  = {hdr_q, copi_lvl};
        hdr_addr  = hdr_full[ADDR_W-1:0];
        hdr_bad   = ({1'b0, hdr_addr} >= (ADDR_W+1)'(NUM_REGS));
        addr_next = (addr_q == ADDR_W'(NUM_REGS-1)) ? '0 : addr_q + 1'b1;
        word      = {wsr_q[DATA_W-2:0], copi_lvl};
        hidx      = hdr_addr[IDX_W-1:0];
        aidx      = addr_q[IDX_W-1:0];
        nidx      = addr_next[IDX_W-1:0];

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        hdr_d     = hdr_q;
        rw_d      = rw_q;
        bad_d     = bad_q;
        addr_d    = addr_q;
        wsr_d     = wsr_q;
        rsr_d     = rsr_q;
        skip_d    = skip_q;
        regs_d    = regs_q;
        wr_stb_d  = '0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = ST_HDR;
                    bit_cnt_d = '0;
                    hdr_d     = '0;
                    bad_d     = 1'b0;
                    rsr_d     = '0;
                    skip_d    = 1'b0;
                end
            end
            ST_HDR: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                        rw_d      = hdr_full[ADDR_W];
                        addr_d    = hdr_addr;
                        bad_d     = hdr_bad;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                        rsr_d     = hdr_bad ? '0 : regs_q[hidx];
                        skip_d    = 1'b1;
                    end else begin
                        hdr_d     = hdr_full[ADDR_W-1:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    wsr_d = word;
                    if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_next;
                        if (rw_q == OP_WRITE && !bad_q) begin
                            regs_d[aidx]   = word;
                            wr_stb_d[aidx] = 1'b1;
                        end
                        // the fall that follows this rise must not consume the new MSB
                        rsr_d  = bad_q ? '0 : regs_q[nidx];
                        skip_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        rsr_d = rsr_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a bit sampled in this same cycle has already been folded in above
        if (cs_rise && state_q != ST_IDLE) begin
            if (state_d == ST_HDR || bad_d || bit_cnt_d != '0) begin
                if (err_q != {ERR_CNT_W{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
            end
            state_d = ST_IDLE;
        end
    end

    // state, datapath and register-bank flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            rw_q      <= OP_READ;
            bad_q     <= 1'b0;
            addr_q    <= '0;
            wsr_q     <= '0;
            rsr_q     <= '0;
            skip_q    <= 1'b0;
            regs_q    <= '{default: RESET_VAL};
            wr_stb_q  <= '0;
            err_q     <= '0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hdr_q     <= hdr_d;
            rw_q      <= rw_d;
            bad_q     <= bad_d;
            addr_q    <= addr_d;
            wsr_q     <= wsr_d;
            rsr_q     <= rsr_d;
            skip_q    <= skip_d;
            regs_q    <= regs_d;
            wr_stb_q  <= wr_stb_d;
            err_q     <= err_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign CIPO    = (state_q == ST_DATA) && (rw_q == OP_READ) && rsr_q[DATA_W-1];
    assign CIPO_oe = ~cs_lvl;
    assign wr_stb  = wr_stb_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - scoreboard bench for spi_regbank
module tb_spi_regbank;

    localparam int HP = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         nCS;
    logic         SCLK;
    logic         COPI;
    logic         CIPO;
    logic         CIPO_oe;
    logic [127:0] reg_q;
    logic [15:0]  wr_stb;
    logic [7:0]   err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_regs [16];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  rxexp_q [$];
    logic [7:0]  exp_err;

    spi_regbank dut (
        .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .CIPO(CIPO), .CIPO_oe(CIPO_oe), .reg_q(reg_q), .wr_stb(wr_stb), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                if (wr_stb[i]) obs_q.push_back({8'(i), reg_q[i*8 +: 8]});
            end
        end
    end

    task automatic wait_hp;
        repeat (HP) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        COPI = b;
        wait_hp();
        r = CIPO;
        SCLK = 1'b1;
        wait_hp();
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic rw, input logic [6:0] addr, input int extra);
        logic [7:0] hdr;
        logic [7:0] w;
        logic [7:0] r8;
        logic       r;
        hdr = {rw, addr};
        nCS = 1'b0;
        wait_hp();
        for (int i = 7; i >= 0; i--) spi_bit(hdr[i], r);
        while (tx_q.size() > 0) begin
            w = tx_q.pop_front();
            for (int i = 7; i >= 0; i--) begin
                spi_bit(w[i], r);
                r8[i] = r;
            end
            rx_q.push_back(r8);
        end
        for (int e = 0; e < extra; e++) spi_bit(1'b1, r);
        wait_hp();
        nCS = 1'b1;
        wait_hp();
        wait_hp();
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b1; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        exp_err = 8'd0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        n_cmp++; if (CIPO !== 1'b0) begin n_bad++; $display("FAIL reset_cipo got %b want 0", CIPO); end
        n_cmp++; if (CIPO_oe !== 1'b0) begin n_bad++; $display("FAIL reset_cipo_oe got %b want 0", CIPO_oe); end
        n_cmp++; if (wr_stb !== 16'h0) begin n_bad++; $display("FAIL reset_wr_stb got %h want 0", wr_stb); end
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL reset_regs got %h want %h", reg_q, model_vec()); end
    endtask

    task automatic test_single_write;
        tx_q.push_back(8'hA5);
        exp_q.push_back({8'd3, 8'hA5}); exp_regs[3] = 8'hA5;
        spi_frame(1'b1, 7'd3, 0);
        rx_q.delete();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_stb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_stb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL single_regs got %h want %h", reg_q, model_vec()); end
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL single_err got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_burst_write;
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        exp_q.push_back({8'd14, 8'h11}); exp_regs[14] = 8'h11;
        exp_q.push_back({8'd15, 8'h22}); exp_regs[15] = 8'h22;
        exp_q.push_back({8'd0,  8'h33}); exp_regs[0]  = 8'h33;
        spi_frame(1'b1, 7'd14, 0);
        rx_q.delete();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL burst_stb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL burst_stb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL burst_regs got %h want %h", reg_q, model_vec()); end
    endtask

    task automatic test_read(input logic [6:0] addr, input int nwords, input logic bad);
        for (int i = 0; i < nwords; i++) begin
            tx_q.push_back(8'h00);
            rxexp_q.push_back(bad ? 8'h00 : exp_regs[(int'(addr) + i) % 16]);
        end
        if (bad) exp_err = exp_err + 8'd1;
        spi_frame(1'b0, addr, 0);
        n_cmp++; if (rx_q.size() !== rxexp_q.size()) begin n_bad++; $display("FAIL read_count got %0d want %0d", rx_q.size(), rxexp_q.size()); end
        while (rx_q.size() > 0 && rxexp_q.size() > 0) begin
            logic [7:0] e, o;
            e = rxexp_q.pop_front(); o = rx_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL read_data addr %0d got %h want %h", addr, o, e); end
        end
        rx_q.delete(); rxexp_q.delete();
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL read_stb got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL read_err got %0d want %0d", err_cnt, exp_err); end
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL read_regs got %h want %h", reg_q, model_vec()); end
    endtask

    task automatic test_bad_addr_write;
        tx_q.push_back(8'h77);
        exp_err = exp_err + 8'd1;
        spi_frame(1'b1, 7'h40, 0);
        rx_q.delete();
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL badaddr_stb got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL badaddr_regs got %h want %h", reg_q, model_vec()); end
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL badaddr_err got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_partial_word;
        tx_q.push_back(8'h5A);
        exp_q.push_back({8'd2, 8'h5A}); exp_regs[2] = 8'h5A;
        exp_err = exp_err + 8'd1;
        spi_frame(1'b1, 7'd2, 4);
        rx_q.delete();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL partial_stb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL partial_stb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL partial_regs got %h want %h", reg_q, model_vec()); end
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL partial_err got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] hdr;
        logic       r;
        hdr = {1'b1, 7'd5};
        nCS = 1'b0;
        wait_hp();
        for (int i = 7; i >= 0; i--) spi_bit(hdr[i], r);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        exp_err = 8'd0;
        for (int i = 0; i < 6; i++) spi_bit(1'b1, r);
        wait_hp();
        nCS = 1'b1;
        wait_hp();
        wait_hp();
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL midrst_stb got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL midrst_regs got %h want %h", reg_q, model_vec()); end
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL midrst_err got %0d want %0d", err_cnt, exp_err); end
        tx_q.push_back(8'h3C);
        exp_q.push_back({8'd1, 8'h3C}); exp_regs[1] = 8'h3C;
        spi_frame(1'b1, 7'd1, 0);
        rx_q.delete();
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL postrst_stb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL postrst_stb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (reg_q !== model_vec()) begin n_bad++; $display("FAIL postrst_regs got %h want %h", reg_q, model_vec()); end
        n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL postrst_err got %0d want %0d", err_cnt, exp_err); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_read(7'd15, 2, 1'b0);
        test_bad_addr_write();
        test_partial_word();
        test_read(7'h50, 1, 1'b1);
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
